// File: rtl/axi_lite_regfile_s_if.sv
// AXI4-Lite bus bundle for axi_lite_regfile_s; signal names follow the slave's port list.
interface axi_lite_regfile_s_if #(
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int AXI_DATA_WIDTH = 32
);
    logic [AXI_ADDR_WIDTH-1:0]   i_axi_awaddr;
    logic [2:0]                  i_axi_awprot;
    logic                        i_axi_awvalid;
    logic                        o_axi_awready;
    logic [AXI_DATA_WIDTH-1:0]   i_axi_wdata;
    logic [AXI_DATA_WIDTH/8-1:0] i_axi_wstrb;
    logic                        i_axi_wvalid;
    logic                        o_axi_wready;
    logic [1:0]                  o_axi_bresp;
    logic                        o_axi_bvalid;
    logic                        i_axi_bready;
    logic [AXI_ADDR_WIDTH-1:0]   i_axi_araddr;
    logic [2:0]                  i_axi_arprot;
    logic                        i_axi_arvalid;
    logic                        o_axi_arready;
    logic [AXI_DATA_WIDTH-1:0]   o_axi_rdata;
    logic [1:0]                  o_axi_rresp;
    logic                        o_axi_rvalid;
    logic                        i_axi_rready;

    modport slave (
        input  i_axi_awaddr, i_axi_awprot, i_axi_awvalid,
        output o_axi_awready,
        input  i_axi_wdata, i_axi_wstrb, i_axi_wvalid,
        output o_axi_wready,
        output o_axi_bresp, o_axi_bvalid,
        input  i_axi_bready,
        input  i_axi_araddr, i_axi_arprot, i_axi_arvalid,
        output o_axi_arready,
        output o_axi_rdata, o_axi_rresp, o_axi_rvalid,
        input  i_axi_rready
    );

    modport master (
        output i_axi_awaddr, i_axi_awprot, i_axi_awvalid,
        input  o_axi_awready,
        output i_axi_wdata, i_axi_wstrb, i_axi_wvalid,
        input  o_axi_wready,
        input  o_axi_bresp, o_axi_bvalid,
        output i_axi_bready,
        output i_axi_araddr, i_axi_arprot, i_axi_arvalid,
        input  o_axi_arready,
        input  o_axi_rdata, o_axi_rresp, o_axi_rvalid,
        output i_axi_rready
    );
endinterface

// File: rtl/axi_lite_regfile_s.sv
// AXI4-Lite slave register file: independent write (AW/W any order) and read paths,
// byte-lane writes, SLVERR outside the register window, count of OKAY writes.
module axi_lite_regfile_s #(
    parameter logic [31:0] AXI_SLAVE_ADDR_BASE = 32'h4000_0000,
    parameter int          AXI_ADDR_WIDTH      = 32,
    parameter int          AXI_DATA_WIDTH      = 32,
    parameter int unsigned AXI_REG_NUM         = 16
) (
    input  logic                 i_axi_lite_clk,
    input  logic                 i_axi_lite_rst,
    axi_lite_regfile_s_if.slave  s_axi,
    output logic [15:0]          o_wr_count
);
    localparam int unsigned IDX_W = $clog2(AXI_REG_NUM);
    localparam logic [AXI_ADDR_WIDTH-1:0] LP_BASE = AXI_ADDR_WIDTH'(AXI_SLAVE_ADDR_BASE);
    localparam logic [AXI_ADDR_WIDTH-1:0] LP_SPAN = AXI_ADDR_WIDTH'(4 * AXI_REG_NUM);
    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {W_IDLE, W_COMMIT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t                   r_wstate;
    rstate_t                   r_rstate;
    logic [AXI_DATA_WIDTH-1:0] r_regs [AXI_REG_NUM];
    logic                      r_aw_held, r_w_held;
    logic [AXI_ADDR_WIDTH-1:0] r_awaddr;
    logic [AXI_DATA_WIDTH-1:0] r_wdata;
    logic [3:0]                r_wstrb;
    logic                      r_awready, r_wready, r_bvalid, r_arready, r_rvalid;
    logic [1:0]                r_bresp, r_rresp;
    logic [AXI_DATA_WIDTH-1:0] r_rdata;
    logic [15:0]               r_wr_count;

    logic [AXI_ADDR_WIDTH-1:0] w_wr_off, w_rd_off;
    logic                      w_wr_hit, w_rd_hit;
    logic [IDX_W-1:0]          w_wr_idx, w_rd_idx;
    logic [AXI_DATA_WIDTH-1:0] w_wmask;
    logic                      w_aw_hs, w_w_hs, w_ar_hs;
    logic                      w_unused;

    assign w_wr_off = r_awaddr - LP_BASE;
    assign w_wr_hit = (r_awaddr >= LP_BASE) && (w_wr_off < LP_SPAN);
    assign w_wr_idx = w_wr_off[IDX_W+1:2];
    assign w_rd_off = s_axi.i_axi_araddr - LP_BASE;
    assign w_rd_hit = (s_axi.i_axi_araddr >= LP_BASE) && (w_rd_off < LP_SPAN);
    assign w_rd_idx = w_rd_off[IDX_W+1:2];
    assign w_wmask  = {{8{r_wstrb[3]}}, {8{r_wstrb[2]}}, {8{r_wstrb[1]}}, {8{r_wstrb[0]}}};
    assign w_aw_hs  = s_axi.i_axi_awvalid && r_awready;
    assign w_w_hs   = s_axi.i_axi_wvalid && r_wready;
    assign w_ar_hs  = s_axi.i_axi_arvalid && r_arready;
    assign w_unused = ^{s_axi.i_axi_awprot, s_axi.i_axi_arprot};

    // Write path: AW and W are latched independently; the commit waits until both are held.
    always_ff @(posedge i_axi_lite_clk) begin
        if (i_axi_lite_rst) begin
            r_wstate   <= W_IDLE;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awaddr   <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_awready  <= 1'b1;
            r_wready   <= 1'b1;
            r_bvalid   <= 1'b0;
            r_bresp    <= RESP_OKAY;
            r_wr_count <= '0;
            for (int unsigned i = 0; i < AXI_REG_NUM; i++) r_regs[i] <= '0;
        end else begin
            case (r_wstate)
                W_IDLE: begin
                    if (w_aw_hs) begin
                        r_aw_held <= 1'b1;
                        r_awaddr  <= s_axi.i_axi_awaddr;
                        r_awready <= 1'b0;
                    end
                    if (w_w_hs) begin
                        r_w_held <= 1'b1;
                        r_wdata  <= s_axi.i_axi_wdata;
                        r_wstrb  <= s_axi.i_axi_wstrb;
                        r_wready <= 1'b0;
                    end
                    if ((r_aw_held || w_aw_hs) && (r_w_held || w_w_hs)) r_wstate <= W_COMMIT;
                end
                W_COMMIT: begin
                    if (w_wr_hit) begin
                        r_regs[w_wr_idx] <= (r_regs[w_wr_idx] & ~w_wmask) | (r_wdata & w_wmask);
                        r_wr_count       <= r_wr_count + 16'd1;
                        r_bresp          <= RESP_OKAY;
                    end else begin
                        r_bresp <= RESP_SLVERR;
                    end
                    r_bvalid <= 1'b1;
                    r_wstate <= W_RESP;
                end
                W_RESP: begin
                    if (s_axi.i_axi_bready) begin
                        r_bvalid  <= 1'b0;
                        r_aw_held <= 1'b0;
                        r_w_held  <= 1'b0;
                        r_awready <= 1'b1;
                        r_wready  <= 1'b1;
                        r_wstate  <= W_IDLE;
                    end
                end
                default: r_wstate <= W_IDLE;
            endcase
        end
    end

    // Read path samples the register array with the pre-commit value on a coincident edge.
    always_ff @(posedge i_axi_lite_clk) begin
        if (i_axi_lite_rst) begin
            r_rstate  <= R_IDLE;
            r_arready <= 1'b1;
            r_rvalid  <= 1'b0;
            r_rresp   <= RESP_OKAY;
            r_rdata   <= '0;
        end else begin
            case (r_rstate)
                R_IDLE: begin
                    if (w_ar_hs) begin
                        r_arready <= 1'b0;
                        r_rvalid  <= 1'b1;
                        r_rdata   <= w_rd_hit ? r_regs[w_rd_idx] : '0;
                        r_rresp   <= w_rd_hit ? RESP_OKAY : RESP_SLVERR;
                        r_rstate  <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (s_axi.i_axi_rready) begin
                        r_rvalid  <= 1'b0;
                        r_arready <= 1'b1;
                        r_rstate  <= R_IDLE;
                    end
                end
                default: r_rstate <= R_IDLE;
            endcase
        end
    end

    assign s_axi.o_axi_awready = r_awready;
    assign s_axi.o_axi_wready  = r_wready;
    assign s_axi.o_axi_bvalid  = r_bvalid;
    assign s_axi.o_axi_bresp   = r_bresp;
    assign s_axi.o_axi_arready = r_arready;
    assign s_axi.o_axi_rvalid  = r_rvalid;
    assign s_axi.o_axi_rresp   = r_rresp;
    assign s_axi.o_axi_rdata   = r_rdata;
    assign o_wr_count          = r_wr_count;
endmodule

// File: tb/tb_axi_lite_regfile_s.sv
// Scoreboard bench for axi_lite_regfile_s: drivers push expected responses, a negedge monitor pops and compares.
module tb_axi_lite_regfile_s;
    localparam longint unsigned BASE = 64'h4000_0000;
    localparam int TMO = 50;

    typedef struct { logic [31:0] data; logic [1:0] resp; } exp_t;

    logic        clk, rst;
    logic [15:0] wr_count;
    int          vectors = 0;
    int          miscompares = 0;
    exp_t        wq[$];
    exp_t        rq[$];
    logic [31:0] mdl [16];
    logic [15:0] mcnt;

    axi_lite_regfile_s_if #(.AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(32)) bus ();

    axi_lite_regfile_s #(
        .AXI_SLAVE_ADDR_BASE(32'h4000_0000),
        .AXI_ADDR_WIDTH(32),
        .AXI_DATA_WIDTH(32),
        .AXI_REG_NUM(16)
    ) dut (
        .i_axi_lite_clk(clk),
        .i_axi_lite_rst(rst),
        .s_axi(bus),
        .o_wr_count(wr_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %08h expected %08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic flag(input string nm);
        vectors++;
        miscompares++;
        $display("FAIL %s: event not as required at %0t", nm, $time);
    endtask

    // Reference model: register window of 16 words at BASE, byte masks, OKAY-write counter.
    function automatic bit in_range(input logic [31:0] a);
        longint unsigned la;
        la = a;
        return (la >= BASE) && ((la - BASE) < 64);
    endfunction

    function automatic int ridx(input logic [31:0] a);
        longint unsigned la;
        la = a;
        return int'((la - BASE) / 4);
    endfunction

    task automatic wr_expect(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [31:0] mask;
        exp_t e;
        if (in_range(a)) begin
            mask = '0;
            for (int b = 0; b < 4; b++) if (s[b]) mask = mask | (32'hFF << (8 * b));
            mdl[ridx(a)] = (mdl[ridx(a)] & ~mask) | (d & mask);
            mcnt = mcnt + 16'd1;
            e.resp = 2'b00;
        end else begin
            e.resp = 2'b10;
        end
        e.data = {16'h0, mcnt};
        wq.push_back(e);
    endtask

    task automatic rd_expect(input logic [31:0] a);
        exp_t e;
        e.data = in_range(a) ? mdl[ridx(a)] : 32'h0;
        e.resp = in_range(a) ? 2'b00 : 2'b10;
        rq.push_back(e);
    endtask

    task automatic send_aw(input logic [31:0] a, input int dly);
        logic rdy;
        repeat (dly) begin @(posedge clk); #1; end
        bus.i_axi_awaddr  = a;
        bus.i_axi_awprot  = 3'($urandom_range(0, 7));
        bus.i_axi_awvalid = 1'b1;
        for (int n = 0; n <= TMO; n++) begin
            @(negedge clk); rdy = bus.o_axi_awready;
            @(posedge clk); #1;
            if (rdy) break;
            if (n == TMO) flag("aw_timeout");
        end
        bus.i_axi_awvalid = 1'b0;
        chk("awready_drop", 32'(bus.o_axi_awready), 32'h0);
    endtask

    task automatic send_w(input logic [31:0] d, input logic [3:0] s, input int dly);
        logic rdy;
        repeat (dly) begin @(posedge clk); #1; end
        bus.i_axi_wdata  = d;
        bus.i_axi_wstrb  = s;
        bus.i_axi_wvalid = 1'b1;
        for (int n = 0; n <= TMO; n++) begin
            @(negedge clk); rdy = bus.o_axi_wready;
            @(posedge clk); #1;
            if (rdy) break;
            if (n == TMO) flag("w_timeout");
        end
        bus.i_axi_wvalid = 1'b0;
        chk("wready_drop", 32'(bus.o_axi_wready), 32'h0);
    endtask

    task automatic send_ar(input logic [31:0] a, input int dly);
        logic rdy;
        repeat (dly) begin @(posedge clk); #1; end
        bus.i_axi_araddr  = a;
        bus.i_axi_arprot  = 3'($urandom_range(0, 7));
        bus.i_axi_arvalid = 1'b1;
        for (int n = 0; n <= TMO; n++) begin
            @(negedge clk); rdy = bus.o_axi_arready;
            @(posedge clk); #1;
            if (rdy) break;
            if (n == TMO) flag("ar_timeout");
        end
        bus.i_axi_arvalid = 1'b0;
        chk("arready_drop", 32'(bus.o_axi_arready), 32'h0);
    endtask

    task automatic wait_b(input int dly);
        bit seen = 0;
        int held = 0;
        for (int n = 1; n <= TMO; n++) begin
            @(negedge clk);
            if (bus.o_axi_bvalid) begin
                if (!seen) begin seen = 1; chk("b_latency", 32'(n), 32'd2); end
                if (bus.i_axi_bready) begin
                    @(posedge clk); #1;
                    bus.i_axi_bready = 1'b0;
                    chk("bvalid_clear", 32'(bus.o_axi_bvalid), 32'h0);
                    return;
                end
                held++;
                if (held >= dly) begin @(posedge clk); #1; bus.i_axi_bready = 1'b1; end
            end
        end
        bus.i_axi_bready = 1'b0;
        flag("b_timeout");
    endtask

    task automatic wait_r(input int dly);
        bit seen = 0;
        int held = 0;
        for (int n = 1; n <= TMO; n++) begin
            @(negedge clk);
            if (bus.o_axi_rvalid) begin
                if (!seen) begin seen = 1; chk("r_latency", 32'(n), 32'd1); end
                if (bus.i_axi_rready) begin
                    @(posedge clk); #1;
                    bus.i_axi_rready = 1'b0;
                    chk("rvalid_clear", 32'(bus.o_axi_rvalid), 32'h0);
                    return;
                end
                held++;
                if (held >= dly) begin @(posedge clk); #1; bus.i_axi_rready = 1'b1; end
            end
        end
        bus.i_axi_rready = 1'b0;
        flag("r_timeout");
    endtask

    task automatic wr_drive(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                            input int awd, input int wd, input int bd);
        if (bd == 0) bus.i_axi_bready = 1'b1;
        fork
            send_aw(a, awd);
            send_w(d, s, wd);
        join
        wait_b(bd);
    endtask

    task automatic rd_drive(input logic [31:0] a, input int ard, input int rd);
        send_ar(a, ard);
        wait_r(rd);
    endtask

    task automatic do_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                         input int awd, input int wd, input int bd);
        wr_expect(a, d, s);
        wr_drive(a, d, s, awd, wd, bd);
    endtask

    task automatic do_rd(input logic [31:0] a, input int ard, input int rd);
        rd_expect(a);
        rd_drive(a, ard, rd);
    endtask

    // Monitor: pops on each B/R handshake; holds R data against the queue head while stalled.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            if (bus.o_axi_bvalid && bus.i_axi_bready) begin
                if (wq.size() == 0) flag("b_unexpected");
                else begin
                    e = wq.pop_front();
                    chk("bresp", 32'(bus.o_axi_bresp), 32'(e.resp));
                    chk("wr_count", 32'(wr_count), e.data);
                end
            end
            if (bus.o_axi_rvalid) begin
                if (rq.size() == 0) flag("r_unexpected");
                else begin
                    e = bus.i_axi_rready ? rq.pop_front() : rq[0];
                    chk(bus.i_axi_rready ? "rdata" : "rdata_stall", bus.o_axi_rdata, e.data);
                    chk("rresp", 32'(bus.o_axi_rresp), 32'(e.resp));
                end
            end
        end
    end

    initial begin
        logic [31:0] a, b, d;
        int ia, ib, op;
        rst = 1'b1;
        bus.i_axi_awaddr = '0; bus.i_axi_awprot = '0; bus.i_axi_awvalid = 1'b0;
        bus.i_axi_wdata = '0;  bus.i_axi_wstrb = '0;  bus.i_axi_wvalid = 1'b0;
        bus.i_axi_bready = 1'b0;
        bus.i_axi_araddr = '0; bus.i_axi_arprot = '0; bus.i_axi_arvalid = 1'b0;
        bus.i_axi_rready = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        mcnt = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        chk("rst_awready", 32'(bus.o_axi_awready), 32'h1);
        chk("rst_wready",  32'(bus.o_axi_wready),  32'h1);
        chk("rst_arready", 32'(bus.o_axi_arready), 32'h1);
        chk("rst_bvalid",  32'(bus.o_axi_bvalid),  32'h0);
        chk("rst_rvalid",  32'(bus.o_axi_rvalid),  32'h0);
        chk("rst_rdata",   bus.o_axi_rdata,        32'h0);
        chk("rst_count",   32'(wr_count),          32'h0);

        do_wr(32'h4000_0008, 32'hAA00_0002, 4'hF, 0, 0, 0);
        do_wr(32'h4000_0004, 32'h1122_3344, 4'b0101, 3, 0, 0);
        do_rd(32'h4000_0004, 0, 0);
        do_rd(32'h4000_0008, 0, 5);
        do_wr(32'h4000_0040, 32'hDEAD_BEEF, 4'hF, 0, 0, 2);
        do_rd(32'h3FFF_FFFC, 0, 0);
        do_wr(32'h4000_0008, 32'h5555_5555, 4'h0, 0, 1, 0);
        for (int i = 0; i < 16; i++) do_rd(32'h4000_0000 + 32'(4 * i), 0, 0);

        for (int i = 0; i < 10; i++) do_wr(32'h4000_0000 + 32'(4 * i), 32'hAA00_0000 + 32'(i), 4'hF, 0, 0, 0);
        for (int i = 0; i < 10; i++) do_rd(32'h4000_0000 + 32'(4 * i) + 32'(i % 4), 0, 0);
        chk("count_after_ten", 32'(wr_count), 32'(mcnt));

        // Read captured on the commit edge of a write to the same register.
        rd_expect(32'h4000_000C);
        wr_expect(32'h4000_000C, 32'h0BAD_F00D, 4'hF);
        fork
            wr_drive(32'h4000_000C, 32'h0BAD_F00D, 4'hF, 0, 0, 0);
            rd_drive(32'h4000_000C, 1, 0);
        join
        do_rd(32'h4000_000C, 0, 0);

        for (int it = 0; it < 80; it++) begin
            op = $urandom_range(0, 6);
            ia = $urandom_range(0, 9);
            if (ia == 0)      a = 32'h4000_0040 + 32'(4 * $urandom_range(0, 63));
            else if (ia == 1) a = 32'h4000_0000 - 32'(4 * $urandom_range(1, 8));
            else              a = 32'h4000_0000 + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
            d = $urandom;
            if (op <= 2) begin
                do_wr(a, d, 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3));
            end else if (op <= 5) begin
                do_rd(a, $urandom_range(0, 2), $urandom_range(0, 3));
            end else begin
                ia = $urandom_range(0, 15);
                ib = (ia + $urandom_range(1, 15)) % 16;
                a = 32'h4000_0000 + 32'(4 * ia);
                b = 32'h4000_0000 + 32'(4 * ib);
                rd_expect(b);
                wr_expect(a, d, 4'hF);
                fork
                    wr_drive(a, d, 4'hF, $urandom_range(0, 2), $urandom_range(0, 2), $urandom_range(0, 2));
                    rd_drive(b, $urandom_range(0, 3), $urandom_range(0, 3));
                join
            end
        end

        // Reset while the write response is stalled.
        bus.i_axi_bready = 1'b0;
        fork
            send_aw(32'h4000_0010, 0);
            send_w(32'h1234_5678, 4'hF, 0);
        join
        for (int n = 0; n <= TMO; n++) begin
            @(negedge clk);
            if (bus.o_axi_bvalid) break;
            if (n == TMO) flag("b_before_reset_timeout");
        end
        @(posedge clk); #1 rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        for (int i = 0; i < 16; i++) mdl[i] = '0;
        mcnt = '0;
        wq.delete();
        rq.delete();
        chk("rst2_bvalid",  32'(bus.o_axi_bvalid),  32'h0);
        chk("rst2_awready", 32'(bus.o_axi_awready), 32'h1);
        chk("rst2_wready",  32'(bus.o_axi_wready),  32'h1);
        chk("rst2_arready", 32'(bus.o_axi_arready), 32'h1);
        chk("rst2_count",   32'(wr_count),          32'h0);
        for (int i = 0; i < 16; i++) do_rd(32'h4000_0000 + 32'(4 * i), 0, 0);

        repeat (3) @(posedge clk);
        #1;
        if (wq.size() != 0 || rq.size() != 0) flag("queue_not_drained");
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
